// File: rtl/vectored_interrupt_controller_pkg.sv
// Shared constants for the vectored interrupt controller: register map and FSM states.
package vectored_interrupt_controller_pkg;

  // Register window addresses on Reg_Addr
  localparam logic [1:0] VIC_REG_MASK    = 2'd0;
  localparam logic [1:0] VIC_REG_PENDING = 2'd1;
  localparam logic [1:0] VIC_REG_EDGE    = 2'd2;
  localparam logic [1:0] VIC_REG_STATUS  = 2'd3;

  // Request handshake states towards the core
  typedef enum logic [1:0] {
    VIC_IDLE = 2'd0,
    VIC_REQ  = 2'd1,
    VIC_GAP  = 2'd2
  } vic_state_e;

endpackage

// File: rtl/vectored_interrupt_controller_arbiter.sv
// Combinational priority picker. In fixed mode the lowest set index wins; in
// rotating mode the search starts at ptr and wraps from NUM_CH-1 back to 0.
module interrupt_priority_arbiter #(
  parameter int NUM_CH = 8,
  parameter int ID_W   = 3
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  input  logic              rr_mode,
  output logic              valid,
  output logic [ID_W-1:0]   idx
);

  // Two passes: channels at/after the start point, then the wrapped-around ones
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!valid && req[i] && (!rr_mode || (ID_W'(i) >= ptr))) begin
        valid = 1'b1;
        idx   = ID_W'(i);
      end
    end
    if (rr_mode) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!valid && req[i] && (ID_W'(i) < ptr)) begin
          valid = 1'b1;
          idx   = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/vectored_interrupt_controller.sv
// External interrupt controller: synchronises NUM_CH request lines, keeps
// per-channel MASK/EDGE/PENDING state, arbitrates, and runs the
// EIC_IntReq/EIC_IntId/EIC_IntAck handshake with the core.
// Handshake: EIC_IntReq rises with a valid EIC_IntId and both stay frozen until
// a one-cycle EIC_IntAck; the request then drops for at least one cycle (GAP)
// before the next one may be raised. Ack outside REQ is ignored.
module vectored_interrupt_controller
  import vectored_interrupt_controller_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int ID_W        = 3,
  parameter int ROUND_ROBIN = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Sys_Clock,
  input  logic              Sys_Reset,
  input  logic [NUM_CH-1:0] Irq_In,
  input  logic              Reg_EnR,
  input  logic              Reg_EnW,
  input  logic [1:0]        Reg_Addr,
  input  logic [31:0]       Reg_DataW,
  output logic [31:0]       Reg_DataR,
  output logic              EIC_IntReq,
  output logic [ID_W-1:0]   EIC_IntId,
  input  logic              EIC_IntAck,
  output logic [1:0]        Dbg_State
);

  localparam logic RR_MODE = (ROUND_ROBIN != 0);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0] synced, sync_prev_q, sync_prev_d, rise;
  logic [NUM_CH-1:0] mask_q, mask_d, edge_q, edge_d, pending_q, pending_d;
  logic [NUM_CH-1:0] ack_clr, w1c_clr;
  logic [31:0]       rdata_q, rdata_d, status_word;
  vic_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic [ID_W-1:0]   id_q, id_d, ptr_q, ptr_d;
  logic              arb_valid;
  logic [ID_W-1:0]   arb_idx;

  if (NUM_CH < 32) begin : g_unused_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^Reg_DataW[31:NUM_CH];
  end

  // Synchroniser shift chain plus a delayed copy of the synced level for edge detection
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], Irq_In};
    synced      = sync_q[SYNC_STAGES-1];
    sync_prev_d = synced;
    rise        = synced & ~sync_prev_q;
  end

  // Software-visible MASK/EDGE writes
  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (Reg_EnW && (Reg_Addr == VIC_REG_MASK)) mask_d = Reg_DataW[NUM_CH-1:0];
    if (Reg_EnW && (Reg_Addr == VIC_REG_EDGE)) edge_d = Reg_DataW[NUM_CH-1:0];
  end

  // Pending: edge channels latch rises (a new rise beats a same-cycle clear), level channels follow the line
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((state_q == VIC_REQ) && EIC_IntAck && (id_q == ID_W'(i))) ack_clr[i] = 1'b1;
    end
    w1c_clr = '0;
    if (Reg_EnW && (Reg_Addr == VIC_REG_PENDING)) w1c_clr = Reg_DataW[NUM_CH-1:0];
    pending_d = (edge_q & ((pending_q & ~(ack_clr | w1c_clr)) | rise)) | (~edge_q & synced);
  end

  // Arbitration uses the registered MASK, so a same-cycle MASK write takes effect next cycle
  interrupt_priority_arbiter #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_arbiter (
    .req     (pending_q & mask_q),
    .ptr     (ptr_q),
    .rr_mode (RR_MODE),
    .valid   (arb_valid),
    .idx     (arb_idx)
  );

  // Request FSM: commit a winner, hold it until ack, then force one low cycle
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      VIC_IDLE: begin
        if (arb_valid) begin
          req_d   = 1'b1;
          id_d    = arb_idx;
          state_d = VIC_REQ;
        end
      end
      VIC_REQ: begin
        if (EIC_IntAck) begin
          req_d   = 1'b0;
          state_d = VIC_GAP;
          ptr_d   = (id_q == ID_W'(NUM_CH - 1)) ? '0 : id_q + 1'b1;
        end
      end
      VIC_GAP: state_d = VIC_IDLE;
      default: begin
        state_d = VIC_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Registered read port; holds its value when not strobed
  always_comb begin
    status_word             = '0;
    status_word[31]         = req_q;
    status_word[ID_W-1:0]   = id_q;
    rdata_d                 = rdata_q;
    if (Reg_EnR) begin
      unique case (Reg_Addr)
        VIC_REG_MASK:    rdata_d = 32'(mask_q);
        VIC_REG_PENDING: rdata_d = 32'(pending_q);
        VIC_REG_EDGE:    rdata_d = 32'(edge_q);
        VIC_REG_STATUS:  rdata_d = status_word;
      endcase
    end
  end

  // State registers; reset discards pending events and withdraws the request at once
  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      sync_q      <= '0;
      sync_prev_q <= '0;
      mask_q      <= '0;
      edge_q      <= '0;
      pending_q   <= '0;
      rdata_q     <= '0;
      state_q     <= VIC_IDLE;
      req_q       <= 1'b0;
      id_q        <= '0;
      ptr_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      mask_q      <= mask_d;
      edge_q      <= edge_d;
      pending_q   <= pending_d;
      rdata_q     <= rdata_d;
      state_q     <= state_d;
      req_q       <= req_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign Reg_DataR  = rdata_q;
  assign EIC_IntReq = req_q;
  assign EIC_IntId  = id_q;
  assign Dbg_State  = state_q;

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Bench for the vectored interrupt controller: a fixed-priority and a
// round-robin instance share all stimulus; expected IDs come from a set-based
// model (lowest member / first member at or after the pointer).
module tb_vectored_interrupt_controller;

  localparam logic [1:0] A_MASK = 2'd0, A_PEND = 2'd1, A_EDGE = 2'd2, A_STAT = 2'd3;

  logic        clk, rst;
  logic [7:0]  irq;
  logic        en_r, en_w, ack;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata_fp, rdata_rr;
  logic        req_fp, req_rr;
  logic [2:0]  id_fp, id_rr;
  logic [1:0]  st_fp, st_rr;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int rr_ptr   = 0;

  vectored_interrupt_controller #(.NUM_CH(8), .ID_W(3), .ROUND_ROBIN(0), .SYNC_STAGES(2)) dut_fp (
    .Sys_Clock(clk), .Sys_Reset(rst), .Irq_In(irq), .Reg_EnR(en_r), .Reg_EnW(en_w),
    .Reg_Addr(addr), .Reg_DataW(wdata), .Reg_DataR(rdata_fp), .EIC_IntReq(req_fp),
    .EIC_IntId(id_fp), .EIC_IntAck(ack), .Dbg_State(st_fp));

  vectored_interrupt_controller #(.NUM_CH(8), .ID_W(3), .ROUND_ROBIN(1), .SYNC_STAGES(2)) dut_rr (
    .Sys_Clock(clk), .Sys_Reset(rst), .Irq_In(irq), .Reg_EnR(en_r), .Reg_EnW(en_w),
    .Reg_Addr(addr), .Reg_DataW(wdata), .Reg_DataR(rdata_rr), .EIC_IntReq(req_rr),
    .EIC_IntId(id_rr), .EIC_IntAck(ack), .Dbg_State(st_rr));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: winner selection from a set of pending+enabled channels
  function automatic int model_lowest(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (((s >> i) & 8'd1) != 0) return i;
    return -1;
  endfunction

  function automatic int model_rr(input logic [7:0] s, input int p);
    for (int i = 0; i < 8; i++) begin
      int c;
      c = (p + i) % 8;
      if (((s >> c) & 8'd1) != 0) return c;
    end
    return -1;
  endfunction

  // Drivers (called at a negedge, return at a negedge)
  task automatic do_reset();
    rst = 1'b1; irq = '0; ack = 1'b0; en_r = 1'b0; en_w = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; rr_ptr = 0;
    @(negedge clk);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    en_w = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    en_w = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] fp, output logic [31:0] rr);
    en_r = 1'b1; addr = a;
    @(negedge clk);
    en_r = 1'b0; fp = rdata_fp; rr = rdata_rr;
  endtask

  task automatic pulse_irq(input logic [7:0] pat);
    irq = pat;
    @(negedge clk);
    irq = '0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (req_fp === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
  endtask

  // Serve every request arising from an edge set and compare IDs against the model
  task automatic serve_requests(input logic [7:0] set);
    logic [7:0] fp_set, rr_set;
    int e_fp, e_rr;
    bit ok;
    fp_set = set; rr_set = set;
    while (fp_set != 0) begin
      wait_req(ok);
      chk_cnt++;
      if (!ok || req_rr !== 1'b1) begin
        $display("FAIL serve_timeout: req_fp=%0b req_rr=%0b want 1/1 set=%h", req_fp, req_rr, fp_set);
        return;
      end else pass_cnt++;
      e_fp = model_lowest(fp_set);
      e_rr = model_rr(rr_set, rr_ptr);
      chk_cnt++;
      if (id_fp !== 3'(e_fp)) $display("FAIL serve_id_fp: got %0d want %0d", id_fp, e_fp);
      else pass_cnt++;
      chk_cnt++;
      if (id_rr !== 3'(e_rr)) $display("FAIL serve_id_rr: got %0d want %0d", id_rr, e_rr);
      else pass_cnt++;
      do_ack();
      fp_set &= ~(8'd1 << e_fp);
      rr_set &= ~(8'd1 << e_rr);
      rr_ptr = (e_rr + 1) % 8;
    end
  endtask

  task automatic test_reset();
    logic [31:0] fp, rr;
    chk_cnt++;
    if ({req_fp, id_fp, req_rr, id_rr} !== 8'h00)
      $display("FAIL reset_outputs: got %h want 00", {req_fp, id_fp, req_rr, id_rr});
    else pass_cnt++;
    for (int a = 0; a < 4; a++) begin
      reg_read(2'(a), fp, rr);
      chk_cnt++;
      if (fp !== 32'h0 || rr !== 32'h0) $display("FAIL reset_reg%0d: got %h/%h want 0", a, fp, rr);
      else pass_cnt++;
    end
  endtask

  task automatic test_edge_latency();
    logic [31:0] fp, rr;
    reg_write(A_MASK, 32'hFF);
    reg_write(A_EDGE, 32'hFF);
    irq = 8'h20;
    @(negedge clk);
    irq = '0;
    for (int c = 0; c < 3; c++) begin
      chk_cnt++;
      if (req_fp !== 1'b0 || req_rr !== 1'b0) $display("FAIL latency_early%0d: got %0b/%0b want 0", c, req_fp, req_rr);
      else pass_cnt++;
      @(negedge clk);
    end
    chk_cnt++;
    if ({req_fp, id_fp, req_rr, id_rr} !== {1'b1, 3'd5, 1'b1, 3'd5})
      $display("FAIL latency_req: got %0b/%0d %0b/%0d want 1/5", req_fp, id_fp, req_rr, id_rr);
    else pass_cnt++;
    do_ack();
    rr_ptr = 6;
    chk_cnt++;
    if (req_fp !== 1'b0 || req_rr !== 1'b0) $display("FAIL ack_drop: got %0b/%0b want 0", req_fp, req_rr);
    else pass_cnt++;
    reg_read(A_PEND, fp, rr);
    chk_cnt++;
    if (fp !== 32'h0 || rr !== 32'h0) $display("FAIL ack_pending: got %h/%h want 0", fp, rr);
    else pass_cnt++;
  endtask

  task automatic test_fixed_priority();
    pulse_irq(8'h24);
    serve_requests(8'h24);
    idle_cycles(8);
    chk_cnt++;
    if (req_fp !== 1'b0 || req_rr !== 1'b0) $display("FAIL prio_no_third: got %0b/%0b want 0", req_fp, req_rr);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    bit ok;
    int e_rr;
    do_reset();
    reg_write(A_MASK, 32'hFF);
    reg_write(A_EDGE, 32'h00);
    irq = 8'h81;
    for (int n = 0; n < 4; n++) begin
      wait_req(ok);
      chk_cnt++;
      if (!ok || req_rr !== 1'b1) $display("FAIL rr_timeout%0d: got %0b/%0b want 1", n, req_fp, req_rr);
      else pass_cnt++;
      e_rr = model_rr(8'h81, rr_ptr);
      chk_cnt++;
      if (id_rr !== 3'(e_rr) || id_fp !== 3'(model_lowest(8'h81)))
        $display("FAIL rr_id%0d: got %0d/%0d want %0d/0", n, id_rr, id_fp, e_rr);
      else pass_cnt++;
      do_ack();
      rr_ptr = (e_rr + 1) % 8;
    end
    irq = '0;
    for (int c = 0; c < 12; c++) begin
      if (req_fp === 1'b1) do_ack(); else @(negedge clk);
    end
    chk_cnt++;
    if (req_fp !== 1'b0 || req_rr !== 1'b0) $display("FAIL rr_drain: got %0b/%0b want 0", req_fp, req_rr);
    else pass_cnt++;
  endtask

  task automatic test_ack_collision();
    logic [31:0] fp, rr;
    bit ok;
    do_reset();
    reg_write(A_MASK, 32'hFF);
    reg_write(A_EDGE, 32'hFF);
    pulse_irq(8'h08);
    wait_req(ok);
    chk_cnt++;
    if (!ok || id_fp !== 3'd3 || id_rr !== 3'd3) $display("FAIL coll_first: got %0b %0d/%0d want 1 3/3", ok, id_fp, id_rr);
    else pass_cnt++;
    irq = 8'h08;
    @(negedge clk);
    irq = '0;
    @(negedge clk);
    do_ack();
    reg_read(A_PEND, fp, rr);
    chk_cnt++;
    if (fp !== 32'h08 || rr !== 32'h08) $display("FAIL coll_pending: got %h/%h want 08", fp, rr);
    else pass_cnt++;
    wait_req(ok);
    chk_cnt++;
    if (!ok || id_fp !== 3'd3 || id_rr !== 3'd3) $display("FAIL coll_second: got %0b %0d/%0d want 1 3/3", ok, id_fp, id_rr);
    else pass_cnt++;
    do_ack();
    rr_ptr = 4;
    reg_read(A_PEND, fp, rr);
    chk_cnt++;
    if (fp !== 32'h0 || rr !== 32'h0) $display("FAIL coll_cleared: got %h/%h want 0", fp, rr);
    else pass_cnt++;
  endtask

  task automatic test_mask_in_req();
    logic [31:0] fp, rr;
    bit ok;
    do_reset();
    reg_write(A_MASK, 32'hFF);
    reg_write(A_EDGE, 32'hFF);
    pulse_irq(8'h02);
    wait_req(ok);
    chk_cnt++;
    if (!ok || id_fp !== 3'd1 || id_rr !== 3'd1) $display("FAIL mask_first: got %0b %0d/%0d want 1 1/1", ok, id_fp, id_rr);
    else pass_cnt++;
    reg_write(A_MASK, 32'h00);
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if ({req_fp, id_fp, req_rr, id_rr} !== {1'b1, 3'd1, 1'b1, 3'd1})
        $display("FAIL mask_hold%0d: got %0b/%0d want 1/1", c, req_fp, id_fp);
      else pass_cnt++;
      @(negedge clk);
    end
    reg_read(A_STAT, fp, rr);
    chk_cnt++;
    if (fp !== 32'h8000_0001 || rr !== 32'h8000_0001) $display("FAIL mask_status: got %h/%h want 80000001", fp, rr);
    else pass_cnt++;
    pulse_irq(8'h04);
    idle_cycles(5);
    do_ack();
    rr_ptr = 2;
    idle_cycles(8);
    chk_cnt++;
    if (req_fp !== 1'b0 || req_rr !== 1'b0) $display("FAIL mask_no_req: got %0b/%0b want 0", req_fp, req_rr);
    else pass_cnt++;
    reg_read(A_PEND, fp, rr);
    chk_cnt++;
    if (fp !== 32'h04 || rr !== 32'h04) $display("FAIL mask_pending: got %h/%h want 04", fp, rr);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] fp, rr;
    bit ok;
    reg_write(A_MASK, 32'hFF);
    pulse_irq(8'h10);
    wait_req(ok);
    chk_cnt++;
    if (!ok) $display("FAIL rst_setup: got req %0b want 1", req_fp);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if (req_fp !== 1'b0 || req_rr !== 1'b0) $display("FAIL rst_async: got %0b/%0b want 0", req_fp, req_rr);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; rr_ptr = 0;
    for (int a = 0; a < 4; a++) begin
      reg_read(2'(a), fp, rr);
      chk_cnt++;
      if (fp !== 32'h0 || rr !== 32'h0) $display("FAIL rst_reg%0d: got %h/%h want 0", a, fp, rr);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [31:0] fp, rr;
    logic [7:0] m, pat;
    do_reset();
    reg_write(A_EDGE, 32'hFF);
    for (int r = 0; r < 20; r++) begin
      m   = 8'($urandom_range(0, 255));
      pat = 8'($urandom_range(1, 255));
      reg_write(A_MASK, {24'h0, m});
      pulse_irq(pat);
      serve_requests(pat & m);
      idle_cycles(8);
      chk_cnt++;
      if (req_fp !== 1'b0 || req_rr !== 1'b0) $display("FAIL rand_idle%0d: got %0b/%0b want 0", r, req_fp, req_rr);
      else pass_cnt++;
      reg_read(A_PEND, fp, rr);
      chk_cnt++;
      if (fp !== {24'h0, pat & ~m} || rr !== {24'h0, pat & ~m})
        $display("FAIL rand_pending%0d: got %h/%h want %h", r, fp, rr, pat & ~m);
      else pass_cnt++;
      reg_write(A_PEND, 32'hFFFF_FFFF);
    end
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", chk_cnt);
    $fatal(1);
  end

  // Sequence and report
  initial begin
    rst = 1'b0; irq = '0; en_r = 1'b0; en_w = 1'b0; ack = 1'b0; addr = '0; wdata = '0;
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_edge_latency();
    test_fixed_priority();
    test_round_robin();
    test_ack_collision();
    test_mask_in_req();
    test_reset_mid_req();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
